// File: rtl/hyper_phy_sched_pkg.sv
// Shared types for the HyperBus transfer scheduler: FSM states, descriptor and chunk records.
// Field widths match the scheduler's default AddrWidth/LenWidth/NumChips parameters.
package hyper_phy_sched_pkg;

  localparam int AddrW  = 32;
  localparam int LenW   = 16;
  localparam int ChipsW = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [LenW-1:0]  len;
    logic             write;
  } desc_t;

  typedef struct packed {
    logic [AddrW-1:0]  addr;
    logic [LenW-1:0]   len;
    logic              write;
    logic [ChipsW-1:0] cs;
  } chunk_t;

  // A word is 2 bytes on one PHY and 4 bytes when both PHYs are ganged.
  function automatic logic [AddrW-1:0] chunk_bytes(logic [LenW-1:0] len, logic gang);
    return gang ? AddrW'({len, 2'b00}) : AddrW'({len, 1'b0});
  endfunction

endpackage

// File: rtl/hyper_phy_sched_if.sv
// Descriptor, configuration and PHY-chunk signals of the scheduler.
// The master modport is the scheduler itself; the slave modport is the front-end/PHY side.
interface hyper_phy_sched_if #(
  parameter int NumPhys   = 2,
  parameter int NumChips  = 2,
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
);

  logic                 cfg_phys_in_use_i;
  logic [LenWidth-1:0]  cfg_max_chunk_i;

  logic                 trx_valid_i;
  logic                 trx_ready_o;
  logic [AddrWidth-1:0] trx_addr_i;
  logic [LenWidth-1:0]  trx_len_i;
  logic                 trx_write_i;
  logic                 trx_done_o;

  logic [NumPhys-1:0]   phy_valid_o;
  logic [NumPhys-1:0]   phy_ready_i;
  logic [AddrWidth-1:0] phy_addr_o;
  logic [LenWidth-1:0]  phy_len_o;
  logic                 phy_write_o;
  logic [NumChips-1:0]  phy_cs_o;
  logic [NumPhys-1:0]   phy_done_i;

  logic                 busy_o;
  logic                 phys_in_use_o;

  modport master (
    input  cfg_phys_in_use_i, cfg_max_chunk_i,
    input  trx_valid_i, trx_addr_i, trx_len_i, trx_write_i,
    output trx_ready_o, trx_done_o,
    output phy_valid_o, phy_addr_o, phy_len_o, phy_write_o, phy_cs_o,
    input  phy_ready_i, phy_done_i,
    output busy_o, phys_in_use_o
  );

  modport slave (
    output cfg_phys_in_use_i, cfg_max_chunk_i,
    output trx_valid_i, trx_addr_i, trx_len_i, trx_write_i,
    input  trx_ready_o, trx_done_o,
    input  phy_valid_o, phy_addr_o, phy_len_o, phy_write_o, phy_cs_o,
    output phy_ready_i, phy_done_i,
    input  busy_o, phys_in_use_o
  );

endinterface

// File: rtl/hyper_phy_sched_chunk_calc.sv
// Combinational chunk sizing: the smallest of remaining words, the programmed maximum
// and the words left before the next chip boundary, plus the one-hot chip select.
module hyper_chunk_calc #(
  parameter int NumChips     = 2,
  parameter int AddrWidth    = 32,
  parameter int LenWidth     = 16,
  parameter int ChipSizeLog2 = 23
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [LenWidth-1:0]  rem_i,
  input  logic [LenWidth-1:0]  max_i,
  input  logic                 gang_i,
  output logic [LenWidth-1:0]  len_o,
  output logic [NumChips-1:0]  cs_o
);

  localparam int ExtW = AddrWidth + 1;
  localparam int IdxW = (NumChips > 1) ? $clog2(NumChips) : 1;

  logic [ExtW-1:0] addrExt;
  logic [ExtW-1:0] boundary;
  logic [ExtW-1:0] distBytes;
  logic [ExtW-1:0] distWords;
  logic [ExtW-1:0] lenExt;
  logic [IdxW-1:0] chipIdx;

  // One extra bit keeps the boundary above the top chip representable.
  always_comb begin
    addrExt   = {1'b0, addr_i};
    boundary  = ((addrExt >> ChipSizeLog2) + ExtW'(1)) << ChipSizeLog2;
    distBytes = boundary - addrExt;
    distWords = gang_i ? (distBytes >> 2) : (distBytes >> 1);
    lenExt    = ExtW'(rem_i);
    if (max_i != '0 && ExtW'(max_i) < lenExt) begin
      lenExt = ExtW'(max_i);
    end
    if (distWords < lenExt) begin
      lenExt = distWords;
    end
    len_o = LenWidth'(lenExt);
  end

  if (NumChips > 1) begin : g_idx
    assign chipIdx = addr_i[ChipSizeLog2 +: IdxW];
  end else begin : g_noidx
    assign chipIdx = '0;
  end

  assign cs_o = NumChips'(1) << chipIdx;

endmodule

// File: rtl/hyper_phy_sched.sv
// Transfer scheduler: accepts one descriptor, splits it into chip- and size-bounded
// chunks and issues each chunk to PHY0 alone or to both PHYs ganged.
module hyper_phy_sched
  import hyper_phy_sched_pkg::*;
#(
  parameter int NumPhys      = 2,
  parameter int NumChips     = ChipsW,
  parameter int AddrWidth    = AddrW,
  parameter int LenWidth     = LenW,
  parameter int ChipSizeLog2 = 23
) (
  input logic               clk_i,
  input logic               rst_ni,
  hyper_phy_sched_if.master bus
);

  localparam logic [NumPhys-1:0] Phy0Only = NumPhys'(1);

  state_e              state_q;
  desc_t               desc_q;
  chunk_t              chunk_q;
  logic                gang_q;
  logic [LenWidth-1:0] maxChunk_q;
  logic [NumPhys-1:0]  valid_q;
  logic [NumPhys-1:0]  doneMask_q;
  logic                ready_q;
  logic                busy_q;
  logic                trxDone_q;

  logic                 gangAccept;
  logic [NumPhys-1:0]   activeMask;
  logic [NumPhys-1:0]   issuedNow;
  logic [NumPhys-1:0]   doneNow;
  logic [AddrWidth-1:0] nextAddr;
  logic [LenWidth-1:0]  nextRem;
  logic [AddrWidth-1:0] calcAddr;
  logic [LenWidth-1:0]  calcRem;
  logic [LenWidth-1:0]  calcMax;
  logic                 calcGang;
  logic [LenWidth-1:0]  calcLen;
  logic [NumChips-1:0]  calcCs;

  assign gangAccept = bus.cfg_phys_in_use_i & (NumPhys == 2);
  assign activeMask = gang_q ? '1 : Phy0Only;
  assign issuedNow  = valid_q & bus.phy_ready_i;
  assign doneNow    = doneMask_q | (bus.phy_done_i & activeMask);

  // The calculator sizes the first chunk from the live descriptor while idle,
  // and the follow-on chunk from the advanced position otherwise.
  always_comb begin
    nextAddr = desc_q.addr + chunk_bytes(chunk_q.len, gang_q);
    nextRem  = desc_q.len - chunk_q.len;
    if (state_q == StIdle) begin
      calcAddr = bus.trx_addr_i;
      calcRem  = bus.trx_len_i;
      calcMax  = bus.cfg_max_chunk_i;
      calcGang = gangAccept;
    end else begin
      calcAddr = nextAddr;
      calcRem  = nextRem;
      calcMax  = maxChunk_q;
      calcGang = gang_q;
    end
  end

  hyper_chunk_calc #(
    .NumChips    (NumChips),
    .AddrWidth   (AddrWidth),
    .LenWidth    (LenWidth),
    .ChipSizeLog2(ChipSizeLog2)
  ) u_chunk_calc (
    .addr_i(calcAddr),
    .rem_i (calcRem),
    .max_i (calcMax),
    .gang_i(calcGang),
    .len_o (calcLen),
    .cs_o  (calcCs)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      desc_q     <= '0;
      chunk_q    <= '0;
      gang_q     <= 1'b0;
      maxChunk_q <= '0;
      valid_q    <= '0;
      doneMask_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      trxDone_q  <= 1'b0;
    end else begin
      trxDone_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.trx_valid_i) begin
            desc_q     <= '{addr: bus.trx_addr_i, len: bus.trx_len_i, write: bus.trx_write_i};
            chunk_q    <= '{addr: bus.trx_addr_i, len: calcLen, write: bus.trx_write_i, cs: calcCs};
            gang_q     <= gangAccept;
            maxChunk_q <= bus.cfg_max_chunk_i;
            valid_q    <= gangAccept ? '1 : Phy0Only;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          valid_q <= valid_q & ~issuedNow;
          if ((valid_q & ~issuedNow) == '0) begin
            doneMask_q <= '0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          doneMask_q <= doneNow;
          if (doneNow == activeMask) begin
            desc_q.addr <= nextAddr;
            desc_q.len  <= nextRem;
            doneMask_q  <= '0;
            if (nextRem == '0) begin
              trxDone_q <= 1'b1;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end else begin
              chunk_q <= '{addr: nextAddr, len: calcLen, write: desc_q.write, cs: calcCs};
              valid_q <= activeMask;
              state_q <= StIssue;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && state_q == StIdle && bus.trx_valid_i) begin
      assert (bus.trx_len_i != '0) else $error("zero-length transfer descriptor");
    end
  end

  assign bus.trx_ready_o   = ready_q;
  assign bus.trx_done_o    = trxDone_q;
  assign bus.phy_valid_o   = valid_q;
  assign bus.phy_addr_o    = chunk_q.addr;
  assign bus.phy_len_o     = chunk_q.len;
  assign bus.phy_write_o   = chunk_q.write;
  assign bus.phy_cs_o      = chunk_q.cs;
  assign bus.busy_o        = busy_q;
  assign bus.phys_in_use_o = gang_q;

endmodule

// File: tb/tb_hyper_phy_sched.sv
// Self-checking bench for hyper_phy_sched: directed scenarios plus randomized transfers,
// each compared against a chunk-list model derived from address/length arithmetic.
module tb_hyper_phy_sched;

  localparam longint ChipBytes = 64'd1 << 23;

  logic clk = 1'b0;
  logic rstN;
  int   assertCount = 0;
  int   failCount   = 0;

  longint   expAddr[$];
  int       expLen[$];
  logic [1:0] expCs[$];

  always #5 clk = ~clk;

  hyper_phy_sched_if #(.NumPhys(2), .NumChips(2), .AddrWidth(32), .LenWidth(16)) bus ();

  hyper_phy_sched #(
    .NumPhys(2), .NumChips(2), .AddrWidth(32), .LenWidth(16), .ChipSizeLog2(23)
  ) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (bus)
  );

  // Reference: walk the transfer in plain integer arithmetic, cutting at max size and chip edges.
  function automatic void build_chunks(longint addr, int len, bit gang, int maxc);
    longint a, ws, left;
    int rem, n;
    expAddr.delete();
    expLen.delete();
    expCs.delete();
    a   = addr;
    rem = len;
    ws  = gang ? 4 : 2;
    while (rem > 0) begin
      left = (ChipBytes - (a % ChipBytes)) / ws;
      n = rem;
      if (maxc != 0 && maxc < n) n = maxc;
      if (left < n) n = int'(left);
      expAddr.push_back(a);
      expLen.push_back(n);
      expCs.push_back((((a / ChipBytes) % 2) == 1) ? 2'b10 : 2'b01);
      a   = a + n * ws;
      rem = rem - n;
    end
  endfunction

  task automatic run_transfer(input logic [31:0] addr, input int len, input bit wr, input bit gang,
                              input int maxc, input int rdyDly0, input int rdyDly1,
                              input bit earlyDone, input bit scrambleCfg);
    logic [1:0] active, issued, expValid, rdy, dn, pending;
    int doneDly[2];
    int c, k;
    build_chunks(longint'(addr), len, gang, maxc);
    active = gang ? 2'b11 : 2'b01;
    bus.cfg_phys_in_use_i = gang;
    bus.cfg_max_chunk_i   = 16'(maxc);
    bus.trx_addr_i        = addr;
    bus.trx_len_i         = 16'(len);
    bus.trx_write_i       = wr;
    bus.trx_valid_i       = 1'b1;
    assertCount++;
    if (bus.trx_ready_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL accept_ready: got %b expected 1", bus.trx_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    bus.trx_valid_i = 1'b0;
    bus.trx_addr_i  = $urandom;
    bus.trx_len_i   = 16'($urandom_range(1, 500));
    bus.trx_write_i = ~wr;
    if (scrambleCfg) begin
      bus.cfg_phys_in_use_i = ~gang;
      bus.cfg_max_chunk_i   = 16'($urandom_range(1, 3));
    end
    assertCount++;
    if ({bus.busy_o, bus.trx_ready_o, bus.phys_in_use_o} !== {1'b1, 1'b0, gang}) begin
      failCount++;
      $display("[TB] FAIL accept_status: got busy/ready/mode %b%b%b expected 10%b",
               bus.busy_o, bus.trx_ready_o, bus.phys_in_use_o, gang);
    end
    for (int i = 0; i < expLen.size(); i++) begin
      issued = 2'b00;
      for (c = 0; issued != active; c++) begin
        if (c > 40) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL issue_timeout: chunk %0d issued %b expected %b", i, issued, active);
          break;
        end
        expValid = active & ~issued;
        assertCount++;
        if ({bus.phy_valid_o, bus.trx_done_o} !== {expValid, 1'b0}) begin
          failCount++;
          $display("[TB] FAIL issue_valid: chunk %0d cycle %0d got valid %b done %b expected %b 0",
                   i, c, bus.phy_valid_o, bus.trx_done_o, expValid);
        end
        assertCount++;
        if ({bus.phy_addr_o, bus.phy_len_o, bus.phy_cs_o, bus.phy_write_o} !==
            {32'(expAddr[i]), 16'(expLen[i]), expCs[i], wr}) begin
          failCount++;
          $display("[TB] FAIL chunk_fields: chunk %0d got addr %h len %0d cs %b wr %b expected addr %h len %0d cs %b wr %b",
                   i, bus.phy_addr_o, bus.phy_len_o, bus.phy_cs_o, bus.phy_write_o,
                   32'(expAddr[i]), expLen[i], expCs[i], wr);
        end
        rdy = {c >= rdyDly1, c >= rdyDly0};
        bus.phy_ready_i = rdy;
        if (earlyDone && (((expValid & rdy) | issued) == active)) bus.phy_done_i = active;
        @(posedge clk);
        issued = issued | (expValid & rdy);
        @(negedge clk);
        bus.phy_ready_i = 2'b00;
        bus.phy_done_i  = 2'b00;
      end
      doneDly[0] = $urandom_range(0, 3);
      doneDly[1] = $urandom_range(0, 3);
      pending = active;
      for (k = 0; pending != 2'b00; k++) begin
        if (k > 10) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL done_timeout: chunk %0d pending %b expected 00", i, pending);
          break;
        end
        dn = 2'b00;
        for (int p = 0; p < 2; p++) if (active[p] && k == doneDly[p]) dn[p] = 1'b1;
        if (!gang && k == 0) dn[1] = 1'b1;
        assertCount++;
        if ({bus.phy_valid_o, bus.trx_done_o} !== 3'b000) begin
          failCount++;
          $display("[TB] FAIL wait_quiet: chunk %0d got valid %b done %b expected 00 0",
                   i, bus.phy_valid_o, bus.trx_done_o);
        end
        bus.phy_done_i = dn;
        @(posedge clk);
        pending = pending & ~dn;
        @(negedge clk);
        bus.phy_done_i = 2'b00;
      end
    end
    assertCount++;
    if ({bus.trx_done_o, bus.trx_ready_o, bus.busy_o, bus.phy_valid_o, bus.phys_in_use_o} !==
        {1'b1, 1'b1, 1'b0, 2'b00, gang}) begin
      failCount++;
      $display("[TB] FAIL trx_done: got done/ready/busy/valid/mode %b%b%b%b%b expected 11000%b",
               bus.trx_done_o, bus.trx_ready_o, bus.busy_o, bus.phy_valid_o, bus.phys_in_use_o, gang);
    end
    @(posedge clk);
    @(negedge clk);
    assertCount++;
    if ({bus.trx_done_o, bus.trx_ready_o} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL done_pulse_width: got done/ready %b%b expected 01",
               bus.trx_done_o, bus.trx_ready_o);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    assertCount++;
    if ({bus.trx_ready_o, bus.trx_done_o, bus.busy_o, bus.phy_valid_o, bus.phys_in_use_o} !== 6'b100000) begin
      failCount++;
      $display("[TB] FAIL reset_status: got ready/done/busy/valid/mode %b%b%b%b%b expected 100000",
               bus.trx_ready_o, bus.trx_done_o, bus.busy_o, bus.phy_valid_o, bus.phys_in_use_o);
    end
    assertCount++;
    if ({bus.phy_addr_o, bus.phy_len_o, bus.phy_cs_o, bus.phy_write_o} !== 51'd0) begin
      failCount++;
      $display("[TB] FAIL reset_chunk: got addr %h len %h cs %b wr %b expected all 0",
               bus.phy_addr_o, bus.phy_len_o, bus.phy_cs_o, bus.phy_write_o);
    end
  endtask

  task automatic test_single_basic();
    run_transfer(32'h8000_0000, 16, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ganged_split();
    run_transfer(32'h0000_1000, 100, 1'b1, 1'b1, 32, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ready_skew();
    run_transfer(32'h0100_0040, 24, 1'b0, 1'b1, 16, 0, 3, 1'b1, 1'b0);
  endtask

  task automatic test_chip_boundary();
    run_transfer(32'h007F_FFF8, 10, 1'b1, 1'b0, 0, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_cfg_toggle();
    run_transfer(32'h0020_0000, 40, 1'b0, 1'b1, 16, 0, 1, 1'b0, 1'b1);
    run_transfer(32'h0020_0100, 12, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.cfg_phys_in_use_i = 1'b1;
    bus.cfg_max_chunk_i   = 16'd0;
    bus.trx_addr_i        = 32'h0000_0200;
    bus.trx_len_i         = 16'd8;
    bus.trx_write_i       = 1'b1;
    bus.trx_valid_i       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.trx_valid_i = 1'b0;
    bus.phy_ready_i = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.phy_ready_i = 2'b00;
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    assertCount++;
    if ({bus.phy_valid_o, bus.trx_ready_o, bus.trx_done_o, bus.busy_o} !== 5'b00100) begin
      failCount++;
      $display("[TB] FAIL reset_mid_status: got valid/ready/done/busy %b%b%b%b expected 00100",
               bus.phy_valid_o, bus.trx_ready_o, bus.trx_done_o, bus.busy_o);
    end
    bus.phy_done_i = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.phy_done_i = 2'b00;
    assertCount++;
    if ({bus.phy_valid_o, bus.trx_ready_o, bus.trx_done_o, bus.phys_in_use_o} !== 5'b00100) begin
      failCount++;
      $display("[TB] FAIL reset_mid_no_done: got valid/ready/done/mode %b%b%b%b expected 00100",
               bus.phy_valid_o, bus.trx_ready_o, bus.trx_done_o, bus.phys_in_use_o);
    end
    run_transfer(32'h0000_0200, 8, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    bit gang;
    int maxc;
    for (int n = 0; n < 25; n++) begin
      gang = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        addr = 32'({$urandom_range(0, 250), 24'h0} + ($urandom_range(0, 1) << 23) + 32'h0080_0000
                   - 4 * $urandom_range(1, 40));
      else
        addr = $urandom_range(0, 32'hFE00_0000);
      addr = gang ? (addr & ~32'h3) : (addr & ~32'h1);
      maxc = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
      run_transfer(addr, $urandom_range(1, 80), 1'($urandom_range(0, 1)), gang, maxc,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    rstN                  = 1'b0;
    bus.cfg_phys_in_use_i = 1'b0;
    bus.cfg_max_chunk_i   = 16'd0;
    bus.trx_valid_i       = 1'b0;
    bus.trx_addr_i        = 32'd0;
    bus.trx_len_i         = 16'd1;
    bus.trx_write_i       = 1'b0;
    bus.phy_ready_i       = 2'b00;
    bus.phy_done_i        = 2'b00;
    @(negedge clk);
    test_reset();
    test_single_basic();
    test_ganged_split();
    test_ready_skew();
    test_chip_boundary();
    test_cfg_toggle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
